multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//   Multi-cycle sequencer for the RV32 core: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
//   and drives the datapath enables that the combinational decoder cannot time on its own.
//   Sits between the instruction register/opcode field, the shared instr/data memory port and the
//   regfile/PC/ALU controls; handshakes with memory via mem_req/mem_ready; counts retired instrs.
// PARAMETERS
//   CNT_W   32   width of retired-instruction counter instret (wraps modulo 2^CNT_W)
// PORTS
//   clk           in   1      system clock, all state updates on rising edge
//   rst           in   1      synchronous reset, active-high
//   opcode        in   7      opcode field of IR (IR[6:0]); stable from DECODE until next FETCH
//   branch_taken  in   1      ALU compare result, valid in EXEC
//   mem_ready     in   1      memory completes current request this cycle
//   mem_req       out  1      memory request, held until mem_ready
//   mem_we        out  1      write strobe (store), only with mem_req
//   mem_is_instr  out  1      1 = address from PC (fetch), 0 = ALU result (data)
//   ir_we         out  1      load IR from memory read data
//   pc_we         out  1      update PC (exactly one pulse per retired instruction)
//   pc_src        out  1      0 = PC+4, 1 = branch target
//   alu_src       out  1      0 = rs2, 1 = immediate
//   aluop         out  2      00 add (ld/st), 01 compare (branch), 10 funct-decoded (R/I-ALU)
//   reg_write     out  1      regfile write enable
//   mem_to_reg    out  1      1 = writeback data from memory
//   retire        out  1      one-cycle pulse coincident with pc_we
//   illegal       out  1      sticky: unsupported opcode decoded
//   state         out  3      FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5 (debug)
//   instret       out  CNT_W  retired-instruction count
// BEHAVIOUR
//   - Reset: state<=FETCH, illegal<=0, instret<=0, opcode latch<=0; while rst=1 all outputs except
//     state/instret forced 0. rst mid-instruction abandons it: no pc_we/reg_write/retire in rst cycle.
//   - Legal opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
//   - FETCH: mem_req=1, mem_is_instr=1, mem_we=0. mem_ready=1 -> ir_we=1 same cycle, go DECODE.
//   - DECODE (1 cycle): latch opcode internally. Illegal -> TRAP; else -> EXEC.
//   - EXEC (1 cycle): alu_src=1 for I-ALU/LOAD/STORE, 0 otherwise; aluop per class.
//     R/I-ALU -> WB. LOAD/STORE -> MEM. BRANCH: pc_we=1, pc_src=branch_taken, retire=1 -> FETCH.
//   - MEM: mem_req=1, mem_is_instr=0, mem_we=(STORE), alu_src=1, aluop=00 held. Wait for mem_ready;
//     LOAD -> WB; STORE: pc_we=1, pc_src=0, retire=1 in ready cycle -> FETCH.
//   - WB (1 cycle): reg_write=1, mem_to_reg=(LOAD), pc_we=1, pc_src=0, retire=1 -> FETCH.
//   - TRAP: all enables 0, no mem_req, illegal=1; held until rst.
//   - Outputs are combinational from state + latched opcode (+ mem_ready/branch_taken where noted);
//     mem_req never drops before mem_ready. mem_ready outside FETCH/MEM is ignored.
//   - instret += 1 on each retire cycle, wraps to 0 at 2^CNT_W.
//   - Latency with zero-wait memory: R/I-ALU 4, LOAD 5, STORE 4, BRANCH 3 cycles; +1 per wait cycle.
// TESTING
//   1 rst 2 cyc, mem_ready=1, opcode=0110011 -> state 0,1,2,4,0; reg_write/pc_we/retire only in WB;
//     aluop=10 alu_src=0 in EXEC; instret=1.
//   2 LOAD 0000011, mem_ready low 3 cyc in MEM -> mem_req held 4 cyc, mem_we=0; WB mem_to_reg=1;
//     total 8 cycles FETCH-to-FETCH.
//   3 BRANCH 1100011, branch_taken=1 then 0 -> EXEC pc_we=1 pc_src=1 / 0, aluop=01, reg_write=0, 3 cyc.
//   4 opcode=1111111 -> TRAP after DECODE, illegal=1, mem_req=0 for 20 cyc, instret unchanged; rst clears.
//   5 STORE 0100011, rst asserted in MEM before mem_ready -> FETCH next cycle, no retire, instret unchanged.
//   6 CNT_W=4, 16 back-to-back R-type instrs -> instret wraps 15 -> 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port between the multi-cycle sequencer
// (master) and the memory subsystem (slave).
interface multicycle_ctrl_if;
  logic mem_req;       // request, held until mem_ready
  logic mem_we;        // store strobe, only valid with mem_req
  logic mem_is_instr;  // 1 = fetch address from PC, 0 = data address from ALU
  logic mem_ready;     // memory completes the current request this cycle

  modport master (
    output mem_req,
    output mem_we,
    output mem_is_instr,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_is_instr,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32 core. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives the datapath enables and the shared
// memory port, and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             alu_src,
  output logic [1:0]       aluop,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             retire,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  state_t           state_q;
  logic [6:0]       opcode_q;
  logic             illegal_q;
  logic [CNT_W-1:0] instret_q;

  logic mem_ready;
  logic mem_req_c;
  logic mem_we_c;
  logic mem_is_instr_c;
  logic retire_c;

  logic is_r;
  logic is_i;
  logic is_ld;
  logic is_st;
  logic is_br;
  logic op_legal;

  assign mem_ready = bus.mem_ready;

  // Instruction class of the opcode latched in DECODE.
  assign is_r  = (opcode_q == OP_R);
  assign is_i  = (opcode_q == OP_I);
  assign is_ld = (opcode_q == OP_LOAD);
  assign is_st = (opcode_q == OP_STORE);
  assign is_br = (opcode_q == OP_BRANCH);

  // Legality is judged on the live IR field, since the latch only loads at the end of DECODE.
  assign op_legal = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                    (opcode == OP_STORE) || (opcode == OP_BRANCH);

  // Sequencer state, opcode latch, sticky illegal flag and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      if (retire_c) begin
        instret_q <= instret_q + CNT_W'(1);
      end
      case (state_q)
        FETCH: begin
          if (mem_ready) begin
            state_q <= DECODE;
          end
        end
        DECODE: begin
          opcode_q <= opcode;
          if (op_legal) begin
            state_q <= EXEC;
          end else begin
            state_q   <= TRAP;
            illegal_q <= 1'b1;
          end
        end
        EXEC: begin
          if (is_br) begin
            state_q <= FETCH;
          end else if (is_ld || is_st) begin
            state_q <= MEM;
          end else begin
            state_q <= WB;
          end
        end
        MEM: begin
          if (mem_ready) begin
            state_q <= is_ld ? WB : FETCH;
          end
        end
        WB: begin
          state_q <= FETCH;
        end
        TRAP: begin
          state_q <= TRAP;
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  // Datapath enables decoded from state and latched opcode; all forced low while in reset
  // so an abandoned instruction can never write the PC or regfile.
  always_comb begin
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_is_instr_c = 1'b0;
    ir_we          = 1'b0;
    pc_we          = 1'b0;
    pc_src         = 1'b0;
    alu_src        = 1'b0;
    aluop          = ALU_ADD;
    reg_write      = 1'b0;
    mem_to_reg     = 1'b0;
    retire_c       = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_req_c      = 1'b1;
          mem_is_instr_c = 1'b1;
          ir_we          = mem_ready;
        end
        EXEC: begin
          alu_src = is_i || is_ld || is_st;
          if (is_br) begin
            aluop    = ALU_CMP;
            pc_we    = 1'b1;
            pc_src   = branch_taken;
            retire_c = 1'b1;
          end else if (is_r || is_i) begin
            aluop = ALU_FUNCT;
          end else begin
            aluop = ALU_ADD;
          end
        end
        MEM: begin
          mem_req_c = 1'b1;
          mem_we_c  = is_st;
          alu_src   = 1'b1;
          aluop     = ALU_ADD;
          if (mem_ready && is_st) begin
            pc_we    = 1'b1;
            retire_c = 1'b1;
          end
        end
        WB: begin
          reg_write  = 1'b1;
          mem_to_reg = is_ld;
          pc_we      = 1'b1;
          retire_c   = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_req      = mem_req_c;
  assign bus.mem_we       = mem_we_c;
  assign bus.mem_is_instr = mem_is_instr_c;
  assign retire           = retire_c;
  assign illegal          = illegal_q && !rst;
  assign state            = state_q;
  assign instret          = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. Stimulus tasks drive one cycle at a
// time and push the hand-computed expected output vector; a negedge monitor
// pops and compares, and separately checks every retire pulse.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  typedef struct packed {
    logic [2:0]  st;
    logic        req;
    logic        we;
    logic        isi;
    logic        irwe;
    logic        pcwe;
    logic        pcsrc;
    logic        alusrc;
    logic [1:0]  aluop;
    logic        regw;
    logic        m2r;
    logic        ret;
    logic        ill;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } vec_t;

  typedef struct packed {
    logic        pcsrc;
    logic        regw;
    logic        m2r;
    logic [31:0] cnt;
  } ret_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic [6:0] opcode = '0;

  logic        ir_we, pc_we, pc_src, alu_src, reg_write, mem_to_reg, retire, illegal;
  logic [1:0]  aluop;
  logic [2:0]  state;
  logic [31:0] instret;

  logic        ir_we4, pc_we4, pc_src4, alu_src4, reg_write4, mem_to_reg4, retire4, illegal4;
  logic [1:0]  aluop4;
  logic [2:0]  state4;
  logic [3:0]  instret4;

  vec_t  trace_q[$];
  string tag_q[$];
  ret_t  ret_q[$];

  logic [31:0] exp_cnt = '0;
  logic [3:0]  exp_cnt4 = '0;
  string       cur = "reset";
  int          n_total = 0;
  int          n_pass = 0;

  vec_t  act_v, exp_v;
  ret_t  act_r, exp_r;
  string tag;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  multicycle_ctrl_if bus4 ();
  assign bus.mem_ready  = mem_ready;
  assign bus4.mem_ready = mem_ready;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus), .opcode(opcode), .branch_taken(branch_taken),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src(alu_src), .aluop(aluop),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .retire(retire), .illegal(illegal),
    .state(state), .instret(instret)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .opcode(opcode), .branch_taken(branch_taken),
    .ir_we(ir_we4), .pc_we(pc_we4), .pc_src(pc_src4), .alu_src(alu_src4), .aluop(aluop4),
    .reg_write(reg_write4), .mem_to_reg(mem_to_reg4), .retire(retire4), .illegal(illegal4),
    .state(state4), .instret(instret4)
  );

  // Argument order: state, mem_req, mem_we, mem_is_instr, ir_we, pc_we, pc_src,
  // alu_src, aluop, reg_write, mem_to_reg, retire, illegal.
  function automatic vec_t mk(input logic [2:0] st, input logic req, input logic we,
                              input logic isi, input logic irwe, input logic pcwe,
                              input logic pcsrc, input logic alusrc, input logic [1:0] aluop_e,
                              input logic regw, input logic m2r, input logic ret,
                              input logic ill);
    vec_t v;
    v = '{st, req, we, isi, irwe, pcwe, pcsrc, alusrc, aluop_e, regw, m2r, ret, ill,
          32'd0, 4'd0};
    return v;
  endfunction

  // One clock cycle: drive inputs just after the edge, record what the DUT must show.
  task automatic step(input logic r, input logic rdy, input logic bt, input vec_t e);
    @(posedge clk);
    #1;
    rst          = r;
    mem_ready    = rdy;
    branch_taken = bt;
    e.cnt  = exp_cnt;
    e.cnt4 = exp_cnt4;
    trace_q.push_back(e);
    tag_q.push_back(cur);
    if (r) begin
      exp_cnt  = '0;
      exp_cnt4 = '0;
    end else if (e.ret) begin
      ret_q.push_back(ret_t'{e.pcsrc, e.regw, e.m2r, exp_cnt});
      exp_cnt  = exp_cnt + 32'd1;
      exp_cnt4 = exp_cnt4 + 4'd1;
    end
  endtask

  task automatic fetch_decode(input logic [6:0] op, input int unsigned waits, input logic idle);
    opcode = op;
    for (int unsigned i = 0; i < waits; i++) begin
      step(1'b0, 1'b0, 1'b0, mk(3'd0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    end
    step(1'b0, 1'b1, 1'b0, mk(3'd0, 1, 0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    step(1'b0, idle, 1'b0, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
  endtask

  task automatic alu_instr(input logic [6:0] op, input logic idle);
    fetch_decode(op, 0, idle);
    step(1'b0, idle, 1'b0, mk(3'd2, 0, 0, 0, 0, 0, 0, (op == OP_I), 2'b10, 0, 0, 0, 0));
    step(1'b0, idle, 1'b0, mk(3'd4, 0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 0, 1, 0));
  endtask

  task automatic load_instr(input int unsigned mem_waits);
    fetch_decode(OP_LOAD, 1, 1'b0);
    step(1'b0, 1'b0, 1'b0, mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
    for (int unsigned i = 0; i < mem_waits; i++) begin
      step(1'b0, 1'b0, 1'b0, mk(3'd3, 1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
    end
    step(1'b0, 1'b1, 1'b0, mk(3'd3, 1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
    step(1'b0, 1'b1, 1'b0, mk(3'd4, 0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 1, 1, 0));
  endtask

  task automatic store_instr(input int unsigned mem_waits);
    fetch_decode(OP_STORE, 0, 1'b1);
    step(1'b0, 1'b1, 1'b0, mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
    for (int unsigned i = 0; i < mem_waits; i++) begin
      step(1'b0, 1'b0, 1'b0, mk(3'd3, 1, 1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
    end
    step(1'b0, 1'b1, 1'b0, mk(3'd3, 1, 1, 0, 0, 1, 0, 1, 2'b00, 0, 0, 1, 0));
  endtask

  task automatic branch_instr(input logic bt);
    fetch_decode(OP_BRANCH, 0, 1'b0);
    step(1'b0, 1'b0, bt, mk(3'd2, 0, 0, 0, 0, 1, bt, 0, 2'b01, 0, 0, 1, 0));
  endtask

  // Monitor: compare one expected vector per cycle and check every retire pulse.
  always @(negedge clk) begin
    act_v = '{state, bus.mem_req, bus.mem_we, bus.mem_is_instr, ir_we, pc_we, pc_src,
              alu_src, aluop, reg_write, mem_to_reg, retire, illegal, instret, instret4};
    if (trace_q.size() > 0) begin
      exp_v = trace_q.pop_front();
      tag   = tag_q.pop_front();
      n_total++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL trace[%s] t=%0t actual=%h required=%h", tag, $time, act_v, exp_v);
    end
    if (retire !== 1'b0) begin
      n_total++;
      if (ret_q.size() == 0) begin
        $display("FAIL retire[%s] t=%0t actual=%b required=no retire", cur, $time, retire);
      end else begin
        exp_r = ret_q.pop_front();
        act_r = '{pc_src, reg_write, mem_to_reg, instret};
        if (act_r === exp_r) n_pass++;
        else $display("FAIL retire[%s] t=%0t actual=%h required=%h", cur, $time, act_r, exp_r);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: two reset cycles, then R-type with memory always ready
    cur = "reset";
    step(1'b1, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    step(1'b1, 1'b1, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    cur = "r_type";
    alu_instr(OP_R, 1'b1);
    cur = "i_alu";
    alu_instr(OP_I, 1'b0);

    // 2: load with three memory wait cycles
    cur = "load_wait";
    load_instr(3);

    // 3: taken then not-taken branch
    cur = "branch_taken";
    branch_instr(1'b1);
    cur = "branch_not_taken";
    branch_instr(1'b0);

    cur = "store";
    store_instr(2);

    // 4: illegal opcode traps; memory activity ignored; reset clears
    cur = "trap";
    fetch_decode(OP_BAD, 0, 1'b1);
    for (int unsigned i = 0; i < 20; i++) begin
      step(1'b0, i[0], 1'b1, mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
    end
    step(1'b1, 1'b0, 1'b0, mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    cur = "after_trap";
    alu_instr(OP_R, 1'b0);

    // 5: reset in MEM of a store, with mem_ready high in the reset cycle
    cur = "store_reset";
    fetch_decode(OP_STORE, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
    step(1'b0, 1'b0, 1'b0, mk(3'd3, 1, 1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
    step(1'b1, 1'b1, 1'b0, mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    cur = "after_store_reset";
    step(1'b0, 1'b0, 1'b0, mk(3'd0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    store_instr(0);

    // 6: reset, then 16 back-to-back R-types; the 4-bit counter wraps to 0
    cur = "wrap";
    step(1'b1, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    for (int unsigned i = 0; i < 16; i++) begin
      alu_instr(OP_R, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, mk(3'd0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));

    repeat (3) @(negedge clk);
    cur = "drain";
    n_total++;
    if (trace_q.size() == 0) n_pass++;
    else $display("FAIL trace_drain: actual=%0d left required=0", trace_q.size());
    n_total++;
    if (ret_q.size() == 0) n_pass++;
    else $display("FAIL retire_drain: actual=%0d missing retires required=0", ret_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
